ctrl_pipe_n: RTL

//  Parametrised control-signal pipeline carrying decoded control words from decode through NUM_STAGES

---
 rtl/ctrl_pipe_n.sv | 101 ++++++++++
 1 files changed

// File: rtl/ctrl_pipe_n.sv
// Control-word pipeline from decode through NUM_STAGES registers.
// Tracks valid bits, resolves branches/jumps in one stage, counts retirements.
module ctrl_pipe_n #(
    parameter int CTRL_W        = 16,
    parameter int NUM_STAGES    = 3,
    parameter int RESOLVE_STAGE = 0,
    parameter int CNT_W         = 32,
    localparam int IW           = $clog2(NUM_STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_d,
    input  logic [CTRL_W-1:0]            ctrl_d,
    input  logic                         branch_d,
    input  logic                         jump_d,
    input  logic                         zero_i,
    input  logic [NUM_STAGES-1:0]        stall_i,
    input  logic [NUM_STAGES-1:0]        flush_i,
    output logic [NUM_STAGES*CTRL_W-1:0] ctrl_o,
    output logic [NUM_STAGES-1:0]        valid_o,
    output logic                         pc_src_o,
    output logic [CNT_W-1:0]             instret_o,
    output logic [IW-1:0]                inflight_o
);

    localparam int N = NUM_STAGES;
    localparam int R = RESOLVE_STAGE;

    logic [N-1:0]      r_valid;
    logic [N-1:0]      r_br;
    logic [N-1:0]      r_jp;
    logic [CTRL_W-1:0] r_ctrl [N];
    logic [CNT_W-1:0]  r_instret;

    logic [N-1:0]      w_up_v;
    logic [N-1:0]      w_up_b;
    logic [N-1:0]      w_up_j;
    logic [N-1:0]      w_up_st;
    logic [CTRL_W-1:0] w_up_c [N];
    logic              w_pc_src;
    logic              w_retire;

    // Upstream source of each register: decode for 0, previous register otherwise
    always_comb begin
        w_up_v[0]  = valid_d;
        w_up_b[0]  = branch_d;
        w_up_j[0]  = jump_d;
        w_up_c[0]  = ctrl_d;
        w_up_st[0] = 1'b0;
        for (int k = 1; k < N; k++) begin
            w_up_v[k]  = r_valid[k-1];
            w_up_b[k]  = r_br[k-1];
            w_up_j[k]  = r_jp[k-1];
            w_up_c[k]  = r_ctrl[k-1];
            w_up_st[k] = stall_i[k-1];
        end
    end

    assign w_pc_src = r_valid[R] & ~stall_i[R]
                    & ((r_br[R] & zero_i) | r_jp[R]);
    assign w_retire = r_valid[N-1] & ~stall_i[N-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid   <= '0;
            r_br      <= '0;
            r_jp      <= '0;
            r_instret <= '0;
            for (int k = 0; k < N; k++) r_ctrl[k] <= '0;
        end else begin
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
            for (int k = 0; k < N; k++) begin
                if (flush_i[k] || (w_pc_src && k <= R) || (!stall_i[k] && w_up_st[k])) begin
                    r_valid[k] <= 1'b0;
                    r_br[k]    <= 1'b0;
                    r_jp[k]    <= 1'b0;
                    r_ctrl[k]  <= '0;
                end else if (!stall_i[k]) begin
                    r_valid[k] <= w_up_v[k];
                    r_br[k]    <= w_up_b[k];
                    r_jp[k]    <= w_up_j[k];
                    r_ctrl[k]  <= w_up_c[k];
                end
            end
        end
    end

    always_comb begin
        ctrl_o     = '0;
        inflight_o = '0;
        for (int k = 0; k < N; k++) begin
            ctrl_o[k*CTRL_W +: CTRL_W] = r_ctrl[k];
            inflight_o = inflight_o + IW'(r_valid[k]);
        end
    end

    assign valid_o   = r_valid;
    assign pc_src_o  = w_pc_src;
    assign instret_o = r_instret;

endmodule
